// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN_DEF-1:0] pc_align(input logic [XLEN_DEF-1:0] pc);
        return {pc[XLEN_DEF-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with flush; head is a registered entry (no bypass).
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    input  logic                         flush,
    output entry_t                       head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full queue is only taken when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch with credit-based request issue and redirect flush.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [XLEN-1:0]  imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt,
    output logic [31:0]      perf_drop_cnt
`endif
);

    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] pc_fetch;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   q_count;
    logic [CW:0]     credit_used;
    logic            q_full;
    logic            q_empty;
    logic            issue;
    logic            push;
    logic            pop;
    logic            drop;
    entry_t          q_head;
    entry_t          q_in;

    // Handshakes: a transfer happens on any cycle where valid && ready are both
    // high; valid never depends on ready. Responses have no ready and are always taken.
    assign credit_used     = {1'b0, q_count} + {1'b0, outstanding};
    assign imem_req_valid  = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr   = pc_fetch;
    assign issue           = imem_req_valid && imem_req_ready;
    assign redirect_target = redirect_pc & ~XLEN'(INSTR_BYTES - 1);

    // Responses to requests issued before a redirect are counted off by discard.
    assign push = imem_rsp_valid && !redirect_valid && (discard == '0);
    assign drop = imem_rsp_valid && !redirect_valid && (discard != '0);
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    assign q_in        = '{instr: imem_rsp_data, pc: rsp_pc};
    assign instr_valid = !q_empty;
    assign instr       = q_empty ? '0 : q_head.instr;
    assign instr_pc    = q_empty ? '0 : q_head.pc;

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (q_in),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_fetch    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc_fetch <= redirect_target;
                rsp_pc   <= redirect_target;
                discard  <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (issue) begin
                    pc_fetch <= pc_fetch + XLEN'(INSTR_BYTES);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
                end
                if (drop) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rsp_valid && outstanding == '0));
            assert (!(push && q_full && !pop));
            assert (outstanding <= CW'(DEPTH) && discard <= CW'(DEPTH));
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (instr_ready && !instr_valid && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect_valid && perf_flush_cnt != '1) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (imem_rsp_valid && (redirect_valid || discard != '0) && perf_drop_cnt != '1) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
